// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (LSB first) with a valid/ready byte input and a registered line output.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO between the handshake and the serialiser.
module uart_tx #(
  parameter int BAUDGEN_PERIOD = 1600,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] d_in,
  output logic       tx_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] LAST_TICK = 16'(BAUDGEN_PERIOD - 1);

  if (BAUDGEN_PERIOD < 2 || BAUDGEN_PERIOD > 65535 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx: illegal BAUDGEN_PERIOD or FIFO_DEPTH");
  end

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic        last_tick;
  logic        load_slot;
  logic        take;
  logic        pending;
  logic [7:0]  next_byte;

  assign last_tick = (timer_q == LAST_TICK);
  // The serialiser can start a new frame from idle or on the final stop-bit cycle.
  assign load_slot = (state_q == IDLE) || (state_q == STOP && last_tick);

`ifdef UART_TX_FIFO_EN
  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           fifo_empty, fifo_full, push;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign ready      = !fifo_full;
  assign push       = valid && !fifo_full;
  assign take       = load_slot && !fifo_empty;
  assign pending    = !fifo_empty;
  assign next_byte  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d   = take ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // NOTE: the storage array has no reset; the pointers alone define what is valid, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
`else
  assign ready     = load_slot;
  assign take      = valid && load_slot;
  assign pending   = 1'b0;
  assign next_byte = d_in;
`endif

  // NOTE: combinational logic uses blocking assignments with every output defaulted first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (state_q != IDLE) timer_d = last_tick ? 16'd0 : timer_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (take) begin
          shift_d = next_byte;
          timer_d = 16'd0;
          state_d = START;
        end
      end
      START: begin
        if (last_tick) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (last_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (last_tick) begin
          if (take) begin
            shift_d = next_byte;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The line level follows the next state so it changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = (state_q != IDLE) || pending;

endmodule
